// File: rtl/key_dir_reader_pkg.sv
// Shared definitions for the snake-game key front end: direction codes and width helpers.
// The optional press queue is selected with `define KEY_QUEUE_EN.
package key_dir_reader_pkg;

  // Direction codes for the default three-key layout; DIR_NONE equals N_KEYS.
  typedef enum logic [1:0] {
    DIR_UP   = 2'd0,
    DIR_DOWN = 2'd1,
    DIR_LEFT = 2'd2,
    DIR_NONE = 2'd3
  } dir_e;

  localparam int DB_CYCLES_50MHZ = 1000000;

  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_dir_reader_debounce.sv
// Per-key 2-FF synchroniser, stable-level debouncer and press (released->pressed) pulse.
module key_debounce
  import key_dir_reader_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_50MHZ
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CNT_W = width_min1(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_ni};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_q[1];
        press_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_dir_reader.sv
// Snake key front end: debounced press capture, one direction code handed out per tick.
// `define KEY_QUEUE_EN replaces the pending flags with an arrival-order press queue.
module key_dir_reader
  import key_dir_reader_pkg::*;
#(
  parameter int N_KEYS     = 3,
  parameter int DB_CYCLES  = DB_CYCLES_50MHZ,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(N_KEYS + 1)
) (
  input  logic              OSC_50,
  input  logic              rst,
  input  logic              tick,
  input  logic [N_KEYS-1:0] KEY,
  output logic [CW-1:0]     control,
  output logic              ctl_valid,
  output logic [N_KEYS-1:0] pend,
  output logic              ovf
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [N_KEYS-1:0] press;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i  (OSC_50),
      .rst_ni (rst),
      .key_ni (KEY[g]),
      .press_o(press[g])
    );
  end

  logic [CW-1:0] control_q, control_d;
  logic          ctl_valid_q, ctl_valid_d;

`ifdef KEY_QUEUE_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int QW    = PTR_W + 1;

  logic [CW-1:0]    mem_q [FIFO_DEPTH];
  logic [CW-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [QW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [N_KEYS-1:0] pend_v;

  always_ff @(posedge OSC_50 or negedge rst) begin
    if (!rst) begin
      control_q   <= CW'(N_KEYS);
      ctl_valid_q <= 1'b0;
      rd_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      control_q   <= control_d;
      ctl_valid_q <= ctl_valid_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge OSC_50) begin
    for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= mem_d[k];
  end

  // Pop first so a press in a tick cycle sees the freed slot; pushes go lowest key first.
  always_comb begin
    control_d   = control_q;
    ctl_valid_d = 1'b0;
    ovf_d       = 1'b0;
    rd_d        = rd_q;
    count_d     = count_q;
    for (int k = 0; k < FIFO_DEPTH; k++) mem_d[k] = mem_q[k];
    if (tick) begin
      if (count_q != '0) begin
        control_d   = mem_q[rd_q];
        ctl_valid_d = 1'b1;
        rd_d        = rd_q + 1'b1;
        count_d     = count_q - 1'b1;
      end else begin
        control_d = CW'(N_KEYS);
      end
    end
    for (int i = 0; i < N_KEYS; i++) begin
      if (press[i]) begin
        if (count_d < QW'(FIFO_DEPTH)) begin
          mem_d[rd_d + count_d[PTR_W-1:0]] = CW'(i);
          count_d = count_d + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pend_v = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (QW'(k) < count_q) begin
        for (int i = 0; i < N_KEYS; i++) begin
          if (mem_q[rd_q + PTR_W'(k)] == CW'(i)) pend_v[i] = 1'b1;
        end
      end
    end
  end

  assign pend = pend_v;
  assign ovf  = ovf_q;
`else
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic [N_KEYS-1:0] cand, sel_mask;
  logic [CW-1:0]     sel_idx;
  logic              sel_hit;

  always_ff @(posedge OSC_50 or negedge rst) begin
    if (!rst) begin
      control_q   <= CW'(N_KEYS);
      ctl_valid_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      control_q   <= control_d;
      ctl_valid_q <= ctl_valid_d;
      pend_q      <= pend_d;
    end
  end

  // A press landing in the tick cycle competes for this tick.
  assign cand = pend_q | press;

  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = CW'(N_KEYS);
    sel_mask = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = CW'(i);
        sel_mask = '0;
        sel_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    control_d   = control_q;
    ctl_valid_d = 1'b0;
    pend_d      = pend_q | press;
    if (tick) begin
      control_d   = sel_idx;
      ctl_valid_d = sel_hit;
      pend_d      = press & ~sel_mask;
    end
  end

  assign pend = pend_q;
  assign ovf  = 1'b0;
`endif

  assign control   = control_q;
  assign ctl_valid = ctl_valid_q;

endmodule

// File: tb/tb_key_dir_reader.sv
// Scoreboarded bench for key_dir_reader with short debounce (DB_CYCLES=4).
module tb_key_dir_reader;

  localparam int N_KEYS = 3;
  localparam int DB     = 4;
  localparam int FD     = 4;

  logic       OSC_50 = 1'b0;
  logic       rst    = 1'b0;
  logic       tick   = 1'b0;
  logic [2:0] KEY    = 3'b000;
  logic [1:0] control;
  logic       ctl_valid;
  logic [2:0] pend;
  logic       ovf;

  int checks  = 0;
  int errors  = 0;
  int ovf_cnt = 0;
  int exp_q[$];

  key_dir_reader #(
    .N_KEYS    (N_KEYS),
    .DB_CYCLES (DB),
    .FIFO_DEPTH(FD)
  ) dut (
    .OSC_50   (OSC_50),
    .rst      (rst),
    .tick     (tick),
    .KEY      (KEY),
    .control  (control),
    .ctl_valid(ctl_valid),
    .pend     (pend),
    .ovf      (ovf)
  );

  always #5 OSC_50 = ~OSC_50;

  always @(negedge OSC_50) if (ovf === 1'b1) ovf_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge OSC_50);
  endtask

  // Drives a one-cycle tick and records what control must become.
  task automatic pulse_tick(input int exp);
    exp_q.push_back(exp);
    tick = 1'b1;
    @(negedge OSC_50);
    tick = 1'b0;
  endtask

  task automatic press_key(input int k);
    KEY[k] = 1'b0;
    wait_cyc(8);
    KEY[k] = 1'b1;
    wait_cyc(8);
  endtask

  task automatic test_reset;
    int exp;
    KEY = 3'b000;
    rst = 1'b0;
    wait_cyc(3);
    checks++; if (control !== 2'd3) begin errors++; $display("FAIL rst_control: got %0d want 3", control); end
    checks++; if (ctl_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ctl_valid); end
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL rst_pend: got %b want 000", pend); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    KEY = 3'b111;
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(10);
    pulse_tick(3);
    exp = exp_q.pop_front();
    checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL rst_tick_control: got %0d want %0d", control, exp); end
    checks++; if (ctl_valid !== 1'b0) begin errors++; $display("FAIL rst_tick_valid: got %b want 0", ctl_valid); end
  endtask

  task automatic test_bounce;
    int exp;
    KEY[1] = 1'b0; wait_cyc(3);
    KEY[1] = 1'b1; wait_cyc(1);
    KEY[1] = 1'b0; wait_cyc(5);
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL bounce_early_pend: got %b want 000", pend); end
    wait_cyc(2);
    checks++; if (pend !== 3'b010) begin errors++; $display("FAIL bounce_pend: got %b want 010", pend); end
    wait_cyc(3);
    KEY[1] = 1'b1;
    wait_cyc(8);
    pulse_tick(1);
    exp = exp_q.pop_front();
    checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL bounce_control: got %0d want %0d", control, exp); end
    checks++; if (ctl_valid !== (exp != N_KEYS)) begin errors++; $display("FAIL bounce_valid: got %b want 1", ctl_valid); end
    wait_cyc(1);
    checks++; if (ctl_valid !== 1'b0) begin errors++; $display("FAIL bounce_valid_pulse: got %b want 0", ctl_valid); end
    checks++; if (control !== 2'd1) begin errors++; $display("FAIL bounce_hold: got %0d want 1", control); end
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL bounce_pend_clr: got %b want 000", pend); end
  endtask

  task automatic test_priority;
    int exp;
    press_key(2);
    press_key(0);
    checks++; if (pend !== 3'b101) begin errors++; $display("FAIL prio_pend: got %b want 101", pend); end
    pulse_tick(0);
    exp = exp_q.pop_front();
    checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL prio_control: got %0d want %0d", control, exp); end
    checks++; if (ctl_valid !== 1'b1) begin errors++; $display("FAIL prio_valid: got %b want 1", ctl_valid); end
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL prio_pend_clr: got %b want 000", pend); end
    wait_cyc(2);
    pulse_tick(3);
    exp = exp_q.pop_front();
    checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL prio_none_control: got %0d want %0d", control, exp); end
    checks++; if (ctl_valid !== 1'b0) begin errors++; $display("FAIL prio_none_valid: got %b want 0", ctl_valid); end
  endtask

  task automatic test_tick_collision;
    int exp;
    press_key(0);
    KEY[2] = 1'b0;
    wait_cyc(6);
    pulse_tick(0);
    exp = exp_q.pop_front();
    checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL coll_control: got %0d want %0d", control, exp); end
    checks++; if (ctl_valid !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b want 1", ctl_valid); end
    checks++; if (pend !== 3'b100) begin errors++; $display("FAIL coll_pend: got %b want 100", pend); end
    KEY[2] = 1'b1;
    wait_cyc(8);
    pulse_tick(2);
    exp = exp_q.pop_front();
    checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL coll_next_control: got %0d want %0d", control, exp); end
    checks++; if (ctl_valid !== 1'b1) begin errors++; $display("FAIL coll_next_valid: got %b want 1", ctl_valid); end
  endtask

  task automatic test_async_reset;
    int exp;
    press_key(0);
    press_key(1);
    checks++; if (pend !== 3'b011) begin errors++; $display("FAIL areset_pre_pend: got %b want 011", pend); end
    KEY[2] = 1'b0;
    wait_cyc(4);
    #2 rst = 1'b0;
    #1;
    checks++; if (control !== 2'd3) begin errors++; $display("FAIL areset_control: got %0d want 3", control); end
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL areset_pend: got %b want 000", pend); end
    checks++; if (ctl_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", ctl_valid); end
    @(negedge OSC_50);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(5);
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL areset_cnt_clr: got %b want 000", pend); end
    wait_cyc(2);
    checks++; if (pend !== 3'b100) begin errors++; $display("FAIL areset_repress: got %b want 100", pend); end
    KEY[2] = 1'b1;
    wait_cyc(8);
    pulse_tick(2);
    exp = exp_q.pop_front();
    checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL areset_tick: got %0d want %0d", control, exp); end
  endtask

`ifdef KEY_QUEUE_EN
  task automatic test_queue;
    int exp;
    int seq[5] = '{2, 0, 1, 2, 3};
    press_key(2);
    press_key(0);
    press_key(1);
    press_key(2);
    checks++; if (pend !== 3'b111) begin errors++; $display("FAIL q_pend: got %b want 111", pend); end
    checks++; if (ovf_cnt !== 0) begin errors++; $display("FAIL q_no_ovf: got %0d pulses want 0", ovf_cnt); end
    press_key(0);
    checks++; if (ovf_cnt !== 1) begin errors++; $display("FAIL q_ovf: got %0d pulses want 1", ovf_cnt); end
    for (int t = 0; t < 5; t++) begin
      pulse_tick(seq[t]);
      exp = exp_q.pop_front();
      checks++; if (control !== 2'(exp)) begin errors++; $display("FAIL q_tick%0d_control: got %0d want %0d", t, control, exp); end
      checks++; if (ctl_valid !== (exp != N_KEYS)) begin errors++; $display("FAIL q_tick%0d_valid: got %b want %b", t, ctl_valid, exp != N_KEYS); end
      wait_cyc(1);
    end
    checks++; if (pend !== 3'b000) begin errors++; $display("FAIL q_pend_empty: got %b want 000", pend); end
  endtask
`else
  task automatic test_no_ovf;
    checks++; if (ovf_cnt !== 0) begin errors++; $display("FAIL no_queue_ovf: got %0d pulses want 0", ovf_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
`ifdef KEY_QUEUE_EN
    test_async_reset();
    test_queue();
`else
    test_priority();
    test_tick_collision();
    test_async_reset();
    test_no_ovf();
`endif
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
